// File: rtl/debug_pkg.sv
// Shared definitions for the debug path: arbiter state encoding, framing
// constants and the command bytes understood by the debug command FSM.
// Pure declarations; no logic, no clocking.
//
// Contents:
//   arb_state_t     - UART TX arbiter states (IDLE, GRANT, SEND, WAIT)
//   BYTES_PER_WORD  - bytes per payload word at the default 32/8 geometry
//   HEADER_TAG      - upper nibble of the optional per-grant header byte
//   CMD_*           - debug command bytes
//   bytes_per()     - bytes per word for any NB/DATA_BITS pair
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_t;

  localparam int DEF_NB         = 32;
  localparam int DEF_DATA_BITS  = 8;
  localparam int BYTES_PER_WORD = DEF_NB / DEF_DATA_BITS;

  localparam logic [3:0] HEADER_TAG = 4'hA;

  // Debug command bytes (ASCII mnemonics so they can be typed on a terminal).
  localparam logic [7:0] CMD_DUMP_PC   = 8'h50;  // 'P'
  localparam logic [7:0] CMD_DUMP_REGS = 8'h52;  // 'R'
  localparam logic [7:0] CMD_DUMP_MEM  = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_STATUS    = 8'h53;  // 'S'

  function automatic int bytes_per(input int nb, input int data_bits);
    return nb / data_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: first set request after ptr, cyclically.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the selection.
//
// Ports:
//   req      in  N_REQ  request vector
//   ptr      in  IDW    last served index; scan starts at ptr+1
//   grant    out N_REQ  one-hot selection (all zero when req is zero)
//   grant_id out IDW    encoded selection (0 when req is zero)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id
);

  logic found;

  // Walk offsets 1..N_REQ from the pointer; the inner loop keeps every
  // vector index a constant so the scan stays a flat priority mux.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[k] && (k == (int'(ptr) + i) % N_REQ)) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          grant_id = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one debug UART transmitter between N_REQ sources, round-robin,
// sending each granted NB-bit word MSB byte first.
// Latency: req sampled at t -> ack at t+1, first start at t+2; next byte one cycle after tx_done.
// Backpressure: requests wait (level, held) while a word is in flight; pacing follows i_uart_tx_done.
//
// Optional feature macro: UART_ARB_HEADER_EN - each grant is prefixed with a
// header byte {HEADER_TAG, grant_id} ahead of the payload bytes.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_req              per-source level request, held until acked
//   i_word             packed words, source k at [k*NB +: NB]
//   o_ack              one-cycle pulse to the source whose word is latched
//   o_grant_id         current / last granted source
//   o_busy             high from grant until the last byte's tx_done
//   o_uart_tx_data     byte presented to uart_tx
//   o_uart_tx_start    one-cycle start pulse to uart_tx
//   i_uart_tx_done     one-cycle byte-complete pulse from uart_tx
module uart_tx_arbiter
  import debug_pkg::*;
#(
  parameter int NB        = 32,
  parameter int DATA_BITS = 8,
  parameter int N_REQ     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB-1:0]      i_word,
  output logic [N_REQ-1:0]         o_ack,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic [DATA_BITS-1:0]     o_uart_tx_data,
  output logic                     o_uart_tx_start,
  input  logic                     i_uart_tx_done
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int BYTES = bytes_per(NB, DATA_BITS);
`ifdef UART_ARB_HEADER_EN
  localparam int TOTAL = BYTES + 1;
`else
  localparam int TOTAL = BYTES;
`endif
  localparam int SW = TOTAL * DATA_BITS;
  localparam int CW = $clog2(TOTAL + 1);

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   ptr;
  logic [SW-1:0]    shreg;
  logic [CW-1:0]    byte_cnt;
  logic [NB-1:0]    sel_word;
  logic [SW-1:0]    load_val;
  logic [N_REQ-1:0] rr_grant;
  logic [IDW-1:0]   rr_id;
  logic             rr_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req      (i_req),
    .ptr      (ptr),
    .grant    (rr_grant),
    .grant_id (rr_id)
  );

  assign rr_any = |rr_grant;

  always_comb begin
    sel_word = i_word[NB-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == IDW'(k)) sel_word = i_word[k*NB +: NB];
    end
  end

`ifdef UART_ARB_HEADER_EN
  assign load_val = {DATA_BITS'({HEADER_TAG, 4'(grant_id)}), sel_word};
`else
  assign load_val = sel_word;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rr_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_SEND;
      ST_SEND:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_uart_tx_done) begin
          state_nxt = (byte_cnt == CW'(TOTAL - 1)) ? ST_IDLE : ST_SEND;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The pointer only moves in GRANT, so a source that keeps its request
  // high after the ack falls behind every other pending source.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grant_id <= '0;
      ptr      <= IDW'(N_REQ - 1);
      shreg    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_any) grant_id <= rr_id;
        end
        ST_GRANT: begin
          shreg    <= load_val;
          byte_cnt <= '0;
          ptr      <= grant_id;
        end
        ST_WAIT: begin
          if (i_uart_tx_done) begin
            shreg    <= shreg << DATA_BITS;
            byte_cnt <= byte_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ack           = (state == ST_GRANT) ? (N_REQ'(1) << grant_id) : '0;
  assign o_grant_id      = grant_id;
  assign o_busy          = (state != ST_IDLE);
  assign o_uart_tx_start = (state == ST_SEND);
  assign o_uart_tx_data  = shreg[SW-1 -: DATA_BITS];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized request sets,
// checked against a word/queue-level model of round-robin order and MSB-first bytes.
// A UART responder answers each start with a randomly delayed done pulse.
module tb_uart_tx_arbiter;

  localparam int NB    = 32;
  localparam int DB    = 8;
  localparam int N     = 4;
  localparam int BYTES = NB / DB;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic [N-1:0]    i_req = '0;
  logic [N*NB-1:0] i_word = '0;
  logic [N-1:0]    o_ack;
  logic [1:0]      o_grant_id;
  logic            o_busy;
  logic [DB-1:0]   o_uart_tx_data;
  logic            o_uart_tx_start;
  logic            uart_done;
  logic            resp_done = 1'b0;
  logic            man_done = 1'b0;
  bit              resp_en = 1'b0;

  assign uart_done = resp_done | man_done;

  uart_tx_arbiter #(.NB(NB), .DATA_BITS(DB), .N_REQ(N)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_req           (i_req),
    .i_word          (i_word),
    .o_ack           (o_ack),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .o_uart_tx_data  (o_uart_tx_data),
    .o_uart_tx_start (o_uart_tx_start),
    .i_uart_tx_done  (uart_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int m_ptr = N - 1;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int         ack_q[$];
  int         exp_id_q[$];

  // UART responder: records each started byte, answers with done later.
  initial begin
    forever begin
      @(negedge i_clk);
      if (resp_en && o_uart_tx_start) begin
        cap_q.push_back(o_uart_tx_data);
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        @(posedge i_clk); #1 resp_done = 1'b1;
        @(posedge i_clk); #1 resp_done = 1'b0;
      end
    end
  end

  // Ack monitor: logs the acked source; a non-one-hot ack logs 99.
  initial begin
    int idx;
    forever begin
      @(negedge i_clk);
      if (o_ack != '0) begin
        idx = -1;
        for (int k = 0; k < N; k++) if (o_ack[k]) idx = (idx == -1) ? k : 99;
        ack_q.push_back(idx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_next(input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_txn(input int id, input logic [NB-1:0] w);
    exp_id_q.push_back(id);
`ifdef UART_ARB_HEADER_EN
    exp_q.push_back({4'hA, 4'(id)});
`endif
    for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(w[b*DB +: DB]);
  endfunction

  function automatic void model_serve(input logic [N-1:0] pend_in);
    logic [N-1:0] pend = pend_in;
    int id;
    while (pend != '0) begin
      id = model_next(pend);
      pend[id] = 1'b0;
      m_ptr = id;
      model_txn(id, i_word[id*NB +: NB]);
    end
  endfunction

  // ---------------- stimulus utilities (no checking) ----------------
  task automatic apply_reset();
    @(posedge i_clk); #1 i_reset = 1'b1; i_req = '0; man_done = 1'b0;
    @(posedge i_clk); #1 i_reset = 1'b0;
    m_ptr = N - 1;
    exp_q.delete(); exp_id_q.delete(); cap_q.delete(); ack_q.delete();
  endtask

  // Raise requests, drop each on its ack (or all after n_grants when held),
  // and return once n_grants acks were seen and the arbiter went idle.
  task automatic serve(input logic [N-1:0] req, input int n_grants, input bit hold,
                       output bit timed_out);
    int cyc = 0;
    resp_en = 1'b1;
    ack_q.delete(); cap_q.delete();
    @(posedge i_clk); #1 i_req = req;
    while ((ack_q.size() < n_grants || o_busy) && cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
      if (!hold && o_ack != '0) i_req = i_req & ~o_ack;
      if (ack_q.size() >= n_grants) i_req = '0;
    end
    i_req = '0;
    resp_en = 1'b0;
    timed_out = (cyc >= 3000);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge i_clk); #1 i_reset = 1'b1; i_req = 4'($urandom());
    i_word = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge i_clk); @(negedge i_clk);
    checks++; if (o_ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b want=0000", o_ack); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++; if (o_uart_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", o_uart_tx_start); end
    checks++; if (o_uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", o_uart_tx_data); end
    checks++; if (o_grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", o_grant_id); end
    @(posedge i_clk); #1 i_req = '0; i_reset = 1'b0;
  endtask

  task automatic test_single_timing();
    int w8;
    apply_reset();
    i_word[1*NB +: NB] = 32'hDEADBEEF;
    model_txn(1, 32'hDEADBEEF);
    @(posedge i_clk); #1 i_req = 4'b0010;
    @(posedge i_clk); @(negedge i_clk);
    checks++; if (o_ack !== 4'b0010 || o_grant_id !== 2'd1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL single_ack got ack=%b id=%0d busy=%b want ack=0010 id=1 busy=1", o_ack, o_grant_id, o_busy); end
    i_req = '0;
    @(negedge i_clk);
    checks++; if (o_uart_tx_start !== 1'b1 || o_uart_tx_data !== exp_q[0]) begin
      failures++; $display("FAIL single_first_start got start=%b data=%h want start=1 data=%h", o_uart_tx_start, o_uart_tx_data, exp_q[0]); end
    @(posedge i_clk); #1;
    for (int b = 1; b <= exp_q.size(); b++) begin
      w8 = $urandom_range(0, 3);
      repeat (w8) begin
        @(negedge i_clk);
        checks++; if (o_uart_tx_start !== 1'b0 || o_uart_tx_data !== exp_q[b-1]) begin
          failures++; $display("FAIL single_wait_hold got start=%b data=%h want start=0 data=%h", o_uart_tx_start, o_uart_tx_data, exp_q[b-1]); end
        @(posedge i_clk); #1;
      end
      man_done = 1'b1;
      @(posedge i_clk); #1 man_done = 1'b0;
      @(negedge i_clk);
      if (b == exp_q.size()) begin
        checks++; if (o_busy !== 1'b0 || o_uart_tx_start !== 1'b0) begin
          failures++; $display("FAIL single_end got busy=%b start=%b want busy=0 start=0", o_busy, o_uart_tx_start); end
      end else begin
        checks++; if (o_uart_tx_start !== 1'b1 || o_uart_tx_data !== exp_q[b]) begin
          failures++; $display("FAIL single_byte%0d got start=%b data=%h want start=1 data=%h", b, o_uart_tx_start, o_uart_tx_data, exp_q[b]); end
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic test_two_sources();
    bit to;
    apply_reset();
    i_word[0*NB +: NB] = 32'h11223344;
    i_word[2*NB +: NB] = 32'h55667788;
    model_serve(4'b0101);
    serve(4'b0101, 2, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL two_timeout got=timeout want=complete"); end
    checks++; if (ack_q.size() !== exp_id_q.size()) begin failures++; $display("FAIL two_ack_count got=%0d want=%0d", ack_q.size(), exp_id_q.size()); end
    for (int i = 0; i < ack_q.size() && i < exp_id_q.size(); i++) begin
      checks++; if (ack_q[i] !== exp_id_q[i]) begin failures++; $display("FAIL two_ack%0d got=%0d want=%0d", i, ack_q[i], exp_id_q[i]); end
    end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL two_byte_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL two_byte%0d got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_all_held();
    bit to;
    int id;
    apply_reset();
    i_word = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int g = 0; g < 6; g++) begin
      id = model_next(4'b1111);
      m_ptr = id;
      model_txn(id, i_word[id*NB +: NB]);
    end
    serve(4'b1111, 6, 1'b1, to);
    checks++; if (to) begin failures++; $display("FAIL held_timeout got=timeout want=complete"); end
    checks++; if (ack_q.size() !== 6) begin failures++; $display("FAIL held_ack_count got=%0d want=6", ack_q.size()); end
    for (int i = 0; i < ack_q.size() && i < exp_id_q.size(); i++) begin
      checks++; if (ack_q[i] !== exp_id_q[i]) begin failures++; $display("FAIL held_ack%0d got=%0d want=%0d", i, ack_q[i], exp_id_q[i]); end
    end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL held_byte_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL held_byte%0d got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_word();
    bit to;
    int cyc = 0;
    int k;
    logic [NB-1:0] w;
    apply_reset();
    i_word[0*NB +: NB] = 32'hCAFEF00D;
    resp_en = 1'b1;
    @(posedge i_clk); #1 i_req = 4'b0001;
    while (cap_q.size() < 2 && cyc < 200) begin
      @(negedge i_clk); cyc++;
      if (o_ack != '0) i_req = '0;
    end
    checks++; if (cap_q.size() !== 2) begin failures++; $display("FAIL midrst_pre_bytes got=%0d want=2", cap_q.size()); end
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(negedge i_clk);
    checks++; if (o_grant_id !== 2'd0 || o_uart_tx_data !== 8'h00) begin
      failures++; $display("FAIL midrst_regs got id=%0d data=%h want id=0 data=00", o_grant_id, o_uart_tx_data); end
    repeat (10) begin
      checks++; if (o_uart_tx_start !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL midrst_idle got start=%b busy=%b want start=0 busy=0", o_uart_tx_start, o_busy); end
      @(negedge i_clk);
    end
    resp_en = 1'b0;
    checks++; if (cap_q.size() !== 2) begin failures++; $display("FAIL midrst_extra_bytes got=%0d want=2", cap_q.size()); end
    m_ptr = N - 1;
    exp_q.delete(); exp_id_q.delete();
    k = $urandom_range(0, N - 1);
    w = $urandom();
    i_word[k*NB +: NB] = w;
    model_txn(k, w);
    serve(4'(1 << k), 1, 1'b0, to);
    checks++; if (to || ack_q.size() !== 1 || ack_q[0] !== k) begin
      failures++; $display("FAIL midrst_regrant got acks=%0d timeout=%b want one ack of %0d", ack_q.size(), to, k); end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL midrst_byte_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_spurious_done();
    int w8;
    int k;
    logic [NB-1:0] w;
    apply_reset();
    @(posedge i_clk); #1 man_done = 1'b1;
    @(posedge i_clk); #1 man_done = 1'b0;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0 || o_uart_tx_start !== 1'b0) begin
      failures++; $display("FAIL spur_idle got busy=%b start=%b want busy=0 start=0", o_busy, o_uart_tx_start); end
    k = $urandom_range(0, N - 1);
    w = $urandom();
    i_word[k*NB +: NB] = w;
    model_txn(k, w);
    @(posedge i_clk); #1 i_req = 4'(1 << k);
    @(posedge i_clk); @(negedge i_clk);
    checks++; if (o_ack !== 4'(1 << k)) begin failures++; $display("FAIL spur_ack got=%b want=%b", o_ack, 4'(1 << k)); end
    @(posedge i_clk); #1 man_done = 1'b1; i_req = '0;
    @(negedge i_clk);
    checks++; if (o_uart_tx_start !== 1'b1 || o_uart_tx_data !== exp_q[0]) begin
      failures++; $display("FAIL spur_first got start=%b data=%h want start=1 data=%h", o_uart_tx_start, o_uart_tx_data, exp_q[0]); end
    @(posedge i_clk); #1 man_done = 1'b0; i_word = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int b = 1; b <= exp_q.size(); b++) begin
      w8 = $urandom_range(0, 3);
      repeat (w8) begin
        @(negedge i_clk);
        checks++; if (o_uart_tx_start !== 1'b0 || o_uart_tx_data !== exp_q[b-1]) begin
          failures++; $display("FAIL spur_wait_hold got start=%b data=%h want start=0 data=%h", o_uart_tx_start, o_uart_tx_data, exp_q[b-1]); end
        @(posedge i_clk); #1 i_word = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      // done held two cycles: the second cycle lands in SEND (or IDLE).
      man_done = 1'b1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      if (b == exp_q.size()) begin
        checks++; if (o_busy !== 1'b0 || o_uart_tx_start !== 1'b0) begin
          failures++; $display("FAIL spur_end got busy=%b start=%b want busy=0 start=0", o_busy, o_uart_tx_start); end
      end else begin
        checks++; if (o_uart_tx_start !== 1'b1 || o_uart_tx_data !== exp_q[b]) begin
          failures++; $display("FAIL spur_byte%0d got start=%b data=%h want start=1 data=%h", b, o_uart_tx_start, o_uart_tx_data, exp_q[b]); end
      end
      @(posedge i_clk); #1 man_done = 1'b0;
    end
    repeat (4) begin
      @(negedge i_clk);
      checks++; if (o_uart_tx_start !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL spur_after got start=%b busy=%b want start=0 busy=0", o_uart_tx_start, o_busy); end
    end
  endtask

  task automatic test_source3_header();
    bit to;
    apply_reset();
    i_word[3*NB +: NB] = 32'h01020304;
    model_serve(4'b1000);
    serve(4'b1000, 1, 1'b0, to);
    checks++; if (to || ack_q.size() !== 1 || o_grant_id !== 2'd3) begin
      failures++; $display("FAIL src3_grant got acks=%0d id=%0d timeout=%b want one ack id=3", ack_q.size(), o_grant_id, to); end
    checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL src3_byte_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL src3_byte%0d got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_rr();
    bit to;
    logic [N-1:0] pend;
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      pend = 4'($urandom_range(1, 15));
      i_word = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_q.delete(); exp_id_q.delete();
      model_serve(pend);
      serve(pend, $countones(pend), 1'b0, to);
      checks++; if (to || ack_q.size() !== exp_id_q.size()) begin
        failures++; $display("FAIL rand%0d_ack_count got=%0d timeout=%b want=%0d", r, ack_q.size(), to, exp_id_q.size()); end
      for (int i = 0; i < ack_q.size() && i < exp_id_q.size(); i++) begin
        checks++; if (ack_q[i] !== exp_id_q[i]) begin failures++; $display("FAIL rand%0d_ack%0d got=%0d want=%0d", r, i, ack_q[i], exp_id_q[i]); end
      end
      checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand%0d_byte_count got=%0d want=%0d", r, cap_q.size(), exp_q.size()); end
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
        checks++; if (cap_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h want=%h", r, i, cap_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_timing();
    test_two_sources();
    test_all_held();
    test_reset_mid_word();
    test_spurious_done();
    test_source3_header();
    test_random_rr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single debug UART transmitter between up to N_REQ debug sources (PC dump, register-file dump, data-memory dump, status).
- Each source presents one NB-bit word with a level request.
- The block grants round-robin, latches the granted word, and serializes it MSB-byte-first into the UART TX handshake.
- Sits between the debug command FSM / dump engines and the uart_tx instance.

Parameters:
- NB, 32: payload word width; must be a multiple of DATA_BITS.
- DATA_BITS, 8: UART byte width.
- N_REQ, 4: number of requesters, range 2..16.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_req  in  N_REQ  per-source request, level, held until acked.
- i_word  in  N_REQ*NB  packed words; source k occupies bits [k*NB +: NB].
- o_ack  out  N_REQ  one-cycle pulse to the granted source when its word is latched.
- o_grant_id  out  clog2(N_REQ)  index of the current/last granted source.
- o_busy  out  1  high from grant until the last byte's tx_done.
- o_uart_tx_data  out  DATA_BITS  byte to transmit.
- o_uart_tx_start  out  1  one-cycle start pulse to uart_tx.
- i_uart_tx_done  in  1  one-cycle pulse from uart_tx when a byte finishes.

Behaviour:
- Reset (i_reset high at a clock edge):
  - State is IDLE.
  - Outputs: o_ack=0, o_busy=0, o_uart_tx_start=0, o_uart_tx_data=0, o_grant_id=0.
  - Byte counter and shift register are 0.
  - RR pointer = N_REQ-1, so source 0 has first priority.
- States: IDLE, GRANT, SEND, WAIT. Outputs are Moore-decoded from registered state and registers.
  - o_ack[k] = (state==GRANT && grant_id==k).
  - o_uart_tx_start = (state==SEND).
  - o_busy = (state!=IDLE).
- IDLE: if any i_req bit is set, select the first set bit scanning cyclically from pointer+1. Latch grant_id, go to GRANT. If no request, stay.
- GRANT (1 cycle):
  - Load the shift register with the granted i_word slice.
  - Clear the byte counter.
  - Update pointer to grant_id.
  - Go to SEND.
- SEND (1 cycle): o_uart_tx_data = shift register top DATA_BITS; start pulses; go to WAIT.
- WAIT:
  - o_uart_tx_data holds stable.
  - On i_uart_tx_done: shift left by DATA_BITS and increment the counter.
  - If the counter was BYTES-1 (BYTES = NB/DATA_BITS), go to IDLE; else go to SEND.
- Latency:
  - Request sampled at edge t gives ack at t+1 and first start at t+2.
  - tx_done at cycle d gives the next start at d+1, or o_busy=0 at d+1 after the last byte.
  - A new grant can be sampled at d+1.
- Boundary rules:
  - i_uart_tx_done is ignored outside WAIT.
  - i_word is sampled only in GRANT; later changes do not affect the word in flight.
  - A request dropped before grant is not served.
  - A request still high after its ack is treated as a new request; RR order makes it wait behind the other pending sources.
  - Only one grant is in flight; no preemption.
  - Reset mid-word discards the partial word; no further start pulse until a new grant.

Optional Feature:
- Macro UART_ARB_HEADER_EN.
- When defined:
  - GRANT also preloads a header byte {4'hA, grant_id zero-extended to 4 bits}.
  - The header is sent first via SEND/WAIT, then the BYTES payload bytes.
  - The transaction is BYTES+1 bytes.
- When undefined: payload only, BYTES bytes per grant, no header logic.

Decomposition:
- Shared package debug_pkg holds:
  - state encodings (IDLE, GRANT, SEND, WAIT);
  - BYTES_PER_WORD = NB/DATA_BITS;
  - HEADER_TAG = 4'hA;
  - the debug command byte constants used by the debug FSM.
- One sub-module, rr_arbiter: request vector and pointer in, one-hot grant and encoded index out, combinational scan.
- The pointer register stays in the parent.

Test Plan:
1. i_req=4'b0010, word1=0xDEADBEEF at t:
   - o_ack=4'b0010 at t+1, o_grant_id=1;
   - start at t+2 with byte 0xDE;
   - bytes 0xAD, 0xBE, 0xEF each start 1 cycle after tx_done;
   - o_busy=0 the cycle after the 4th done.
2. After reset, i_req=4'b0101, word0=0x11223344, word2=0x55667788, both held until acked:
   - ack0 first, bytes 11 22 33 44;
   - then ack2, bytes 55 66 77 88.
3. All four requests held continuously: grant order 0,1,2,3,0,1.
4. Reset asserted after 2 bytes of 0xCAFEF00D:
   - o_uart_tx_start stays 0 and o_busy=0;
   - the next request sends all 4 bytes of the new word, starting MSB.
5. Spurious tx_done in IDLE and in SEND, and i_word changed during WAIT:
   - no extra bytes, no shift;
   - the transmitted word equals the value latched at GRANT.
6. With UART_ARB_HEADER_EN, source 3 word 0x01020304: bytes A3 01 02 03 04.
